prs_event_sched: RTL and testbench

Hardware timed-event scheduler for production-rule node transitions: it holds at most one pending transition per output node, counts each one down, and applies it to the node value when its delay expires. It resolves vacuous and unstable (glitching) enqueues the way the prsim kernel does, including optional unstable-dequeue. It sits between stimulus drivers and the modelled node outputs, and it reports the next due event so a host can advance time in bounded steps.

---
 rtl/prs_event_sched.sv | 136 +++++++++++++
 tb/tb_prs_event_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prs_event_sched.sv
// rtl/prs_event_sched.sv - per-node timed transition scheduler with vacuous/unstable resolution
module prs_event_sched #(
  parameter int  NODES = 4,
  parameter int  DW    = 8,
  localparam int NW    = $clog2(NODES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [NW-1:0]    enq_node,
  input  logic             enq_val,
  input  logic [DW-1:0]    enq_delay,
  input  logic             unstable_dequeue,
  input  logic             hold,
  output logic [NODES-1:0] node_val,
  output logic [NODES-1:0] fire_mask,
  output logic             vacuous,
  output logic             unstable,
  output logic [NW:0]      pend_count,
  output logic             next_valid,
  output logic [DW-1:0]    next_due
);

  localparam logic [DW-1:0] CNT_ONE = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [NW:0]   PC_ONE  = {{NW{1'b0}}, 1'b1};

  logic [NODES-1:0] pend_q, pend_d;
  logic [NODES-1:0] pval_q, pval_d;
  logic [NODES-1:0] val_q, val_d;
  logic [NODES-1:0] fire_q, fire_d;
  logic [DW-1:0]    cnt_q [NODES];
  logic [DW-1:0]    cnt_d [NODES];
  logic             vac_q, vac_d;
  logic             unst_q, unst_d;
  logic             rdy_q;
  logic [DW-1:0]    delay_eff;
  logic [NW:0]      pc_acc;
  logic [DW-1:0]    min_acc;
  logic             any_pend;

  // A zero delay would never fire, so it is promoted to one cycle.
  assign delay_eff = (enq_delay == '0) ? CNT_ONE : enq_delay;

  // Fire/decrement first, then judge the enqueue against the post-fire slot.
  always_comb begin
    pend_d = pend_q;
    pval_d = pval_q;
    val_d  = val_q;
    cnt_d  = cnt_q;
    fire_d = '0;
    vac_d  = 1'b0;
    unst_d = 1'b0;
    if (!hold) begin
      for (int i = 0; i < NODES; i++) begin
        if (pend_q[i]) begin
          if (cnt_q[i] == CNT_ONE) begin
            val_d[i]  = pval_q[i];
            fire_d[i] = 1'b1;
            pend_d[i] = 1'b0;
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
      end
    end
    if (enq_valid && rdy_q && (32'(enq_node) < NODES)) begin
      if (!pend_d[enq_node]) begin
        if (enq_val != val_d[enq_node]) begin
          pend_d[enq_node] = 1'b1;
          pval_d[enq_node] = enq_val;
          cnt_d[enq_node]  = delay_eff;
        end else begin
          vac_d = 1'b1;
        end
      end else if (pval_d[enq_node] == enq_val) begin
        // Same-direction re-enqueue keeps the original deadline.
        vac_d = 1'b1;
      end else begin
        unst_d = 1'b1;
        if (unstable_dequeue) begin
          pend_d[enq_node] = 1'b0;
          cnt_d[enq_node]  = '0;
        end
      end
    end
  end

  // Slot and status registers; reset discards every pending event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      pval_q <= '0;
      val_q  <= '0;
      fire_q <= '0;
      vac_q  <= 1'b0;
      unst_q <= 1'b0;
      rdy_q  <= 1'b0;
      for (int i = 0; i < NODES; i++) cnt_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      pval_q <= pval_d;
      val_q  <= val_d;
      fire_q <= fire_d;
      vac_q  <= vac_d;
      unst_q <= unst_d;
      rdy_q  <= 1'b1;
      for (int i = 0; i < NODES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Pending count and earliest remaining count over live slots.
  always_comb begin
    pc_acc   = '0;
    min_acc  = '1;
    any_pend = 1'b0;
    for (int i = 0; i < NODES; i++) begin
      if (pend_q[i]) begin
        pc_acc   = pc_acc + PC_ONE;
        any_pend = 1'b1;
        if (cnt_q[i] < min_acc) min_acc = cnt_q[i];
      end
    end
  end

  assign enq_ready  = rdy_q;
  assign node_val   = val_q;
  assign fire_mask  = fire_q;
  assign vacuous    = vac_q;
  assign unstable   = unst_q;
  assign pend_count = pc_acc;
  assign next_valid = any_pend;
  assign next_due   = any_pend ? min_acc : '0;

endmodule

// File: tb/tb_prs_event_sched.sv
// tb/tb_prs_event_sched.sv - scoreboard bench for prs_event_sched
module tb_prs_event_sched;
  localparam int NODES = 4;
  localparam int DW    = 8;
  localparam int NW    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enq_valid = 1'b0;
  logic             enq_ready;
  logic [NW-1:0]    enq_node = '0;
  logic             enq_val = 1'b0;
  logic [DW-1:0]    enq_delay = '0;
  logic             unstable_dequeue = 1'b0;
  logic             hold = 1'b0;
  logic [NODES-1:0] node_val;
  logic [NODES-1:0] fire_mask;
  logic             vacuous;
  logic             unstable;
  logic [NW:0]      pend_count;
  logic             next_valid;
  logic [DW-1:0]    next_due;

  always #5 clk = ~clk;

  prs_event_sched #(.NODES(NODES), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_node(enq_node),
    .enq_val(enq_val), .enq_delay(enq_delay),
    .unstable_dequeue(unstable_dequeue), .hold(hold),
    .node_val(node_val), .fire_mask(fire_mask),
    .vacuous(vacuous), .unstable(unstable),
    .pend_count(pend_count), .next_valid(next_valid), .next_due(next_due)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int fm; int vac; int uns; int nv; int pc; int nvld; int nd;
  } exp_t;

  exp_t sb[$];

  int m_val [NODES];
  int m_pend[NODES];
  int m_pval[NODES];
  int m_cnt [NODES];
  int m_rdy;

  // Reference model: advances on each edge and queues the outputs expected after it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) begin
        m_val[i] = 0; m_pend[i] = 0; m_pval[i] = 0; m_cnt[i] = 0;
      end
      m_rdy = 0;
      sb.delete();
    end else begin
      exp_t e;
      int n, d;
      e.fm = 0; e.vac = 0; e.uns = 0; e.pc = 0; e.nd = 0; e.nv = 0; e.nvld = 0;
      if (!hold) begin
        for (int i = 0; i < NODES; i++) begin
          if (m_pend[i] != 0) begin
            if (m_cnt[i] == 1) begin
              m_val[i] = m_pval[i]; m_pend[i] = 0; e.fm |= (1 << i);
            end else begin
              m_cnt[i]--;
            end
          end
        end
      end
      if (enq_valid && m_rdy != 0) begin
        n = int'(enq_node);
        d = (enq_delay == 0) ? 1 : int'(enq_delay);
        if (m_pend[n] == 0) begin
          if (int'(enq_val) != m_val[n]) begin
            m_pend[n] = 1; m_pval[n] = int'(enq_val); m_cnt[n] = d;
          end else e.vac = 1;
        end else if (m_pval[n] == int'(enq_val)) begin
          e.vac = 1;
        end else begin
          e.uns = 1;
          if (unstable_dequeue) m_pend[n] = 0;
        end
      end
      m_rdy = 1;
      e.nd = 1 << DW;
      for (int i = 0; i < NODES; i++) begin
        e.nv |= (m_val[i] << i);
        if (m_pend[i] != 0) begin
          e.pc++;
          if (m_cnt[i] < e.nd) e.nd = m_cnt[i];
        end
      end
      e.nvld = (e.pc != 0) ? 1 : 0;
      if (e.pc == 0) e.nd = 0;
      sb.push_back(e);
    end
  end

  // Compare DUT outputs against the queued expectation, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("fire_mask",  32'(fire_mask),  32'(e.fm));
      check("vacuous",    32'(vacuous),    32'(e.vac));
      check("unstable",   32'(unstable),   32'(e.uns));
      check("node_val",   32'(node_val),   32'(e.nv));
      check("pend_count", 32'(pend_count), 32'(e.pc));
      check("next_valid", 32'(next_valid), 32'(e.nvld));
      check("next_due",   32'(next_due),   32'(e.nd));
      check("enq_ready",  32'(enq_ready),  32'd1);
    end
  end

  task automatic enq(input int n, input bit v, input int d);
    enq_node  = 2'(n);
    enq_val   = v;
    enq_delay = 8'(d);
    enq_valid = 1'b1;
    @(negedge clk);
    enq_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_node_val"},   32'(node_val),   32'd0);
    check({tag, "_fire_mask"},  32'(fire_mask),  32'd0);
    check({tag, "_vacuous"},    32'(vacuous),    32'd0);
    check({tag, "_unstable"},   32'(unstable),   32'd0);
    check({tag, "_enq_ready"},  32'(enq_ready),  32'd0);
    check({tag, "_pend_count"}, 32'(pend_count), 32'd0);
    check({tag, "_next_valid"}, 32'(next_valid), 32'd0);
    check({tag, "_next_due"},   32'(next_due),   32'd0);
  endtask

  initial begin
    idle(2);
    check_reset_outputs("rst0");
    #2 rst_n = 1'b1;
    idle(1);
    check("ready_after_rst", 32'(enq_ready), 32'd1);

    // Two staggered events; node 1 due first.
    enq(0, 1'b1, 80);
    enq(1, 1'b1, 20);
    check("t1_next_due", 32'(next_due), 32'd20);
    check("t1_pc2", 32'(pend_count), 32'd2);
    idle(19);
    check("t1_n1_before", 32'(node_val[1]), 32'd0);
    idle(1);
    check("t1_n1_fire", 32'(node_val[1]), 32'd1);
    check("t1_pc1", 32'(pend_count), 32'd1);
    idle(58);
    check("t1_n0_before", 32'(node_val[0]), 32'd0);
    idle(1);
    check("t1_n0_fire", 32'(node_val[0]), 32'd1);
    check("t1_pc0", 32'(pend_count), 32'd0);

    // Vacuous: node already holds the requested value.
    enq(0, 1'b1, 5);
    check("t2_vacuous", 32'(vacuous), 32'd1);
    check("t2_pc", 32'(pend_count), 32'd0);

    // Unstable with dequeue: pending event is cancelled.
    unstable_dequeue = 1'b1;
    enq(0, 1'b0, 80);
    idle(9);
    enq(0, 1'b1, 3);
    check("t3_unstable", 32'(unstable), 32'd1);
    check("t3_vac_excl", 32'(vacuous), 32'd0);
    check("t3_pc", 32'(pend_count), 32'd0);
    idle(80);
    check("t3_n0_kept", 32'(node_val[0]), 32'd1);

    // Unstable warn-only: original event still fires on time.
    unstable_dequeue = 1'b0;
    enq(0, 1'b0, 80);
    idle(9);
    enq(0, 1'b1, 3);
    check("t4_unstable", 32'(unstable), 32'd1);
    check("t4_pc", 32'(pend_count), 32'd1);
    idle(69);
    check("t4_n0_before", 32'(node_val[0]), 32'd1);
    idle(1);
    check("t4_n0_fire", 32'(node_val[0]), 32'd0);
    check("t4_fm", 32'(fire_mask), 32'd1);

    // Hold for five edges with node 1 due in three.
    enq(1, 1'b0, 3);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("t5_frozen_due", 32'(next_due), 32'd3);
    end
    hold = 1'b0;
    idle(2);
    check("t5_n1_before", 32'(node_val[1]), 32'd1);
    idle(1);
    check("t5_n1_fire", 32'(node_val[1]), 32'd0);

    // Simultaneous fire on n0/n2 plus a same-edge re-enqueue on n0.
    enq(0, 1'b1, 6);
    enq(2, 1'b1, 5);
    idle(4);
    enq(0, 1'b0, 4);
    check("t6_fm", 32'(fire_mask), 32'd5);
    check("t6_nv", 32'(node_val), 32'd5);
    check("t6_pc", 32'(pend_count), 32'd1);
    idle(3);
    check("t6_n0_before", 32'(node_val[0]), 32'd1);
    idle(1);
    check("t6_n0_fire", 32'(node_val[0]), 32'd0);

    // Reset mid-countdown.
    enq(1, 1'b1, 50);
    idle(3);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    idle(3);
    check_reset_outputs("rst_hold");
    #2 rst_n = 1'b1;
    idle(2);
    check("post_rst_pc", 32'(pend_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
